wb_reg_file: RTL and testbench
==============================

WB_REG_FILE -- requirements
Module: wb_reg_file

Interface
REQ-001 The block SHALL have these ports, one clock and asynchronous active-high reset, listed as name, direction, width, meaning:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  asynchronous active-high reset.
- WriteRegIn  input  1  writeback enable, driven from the MEM/WB register.
- MemToRegIn  input  1  1 selects memory data, 0 selects ALU result.
- dataMemoryDataIn  input  32  load data from MEM/WB.
- ALUResultIn  input  32  ALU result from MEM/WB.
- registerIn  input  5  destination register number from MEM/WB.
- readReg1  input  5  read port 1 address (ID stage).
- readReg2  input  5  read port 2 address (ID stage).
- readData1  output  32  read port 1 data.
- readData2  output  32  read port 2 data.
- writeDataOut  output  32  selected writeback value, for the forwarding unit.
- writeCount  output  16  count of committed register writes.

Function
REQ-002 The block SHALL compute writeDataOut combinationally as dataMemoryDataIn when MemToRegIn=1, else ALUResultIn.
REQ-003 On posedge clk with WriteRegIn=1 and registerIn!=0, the block SHALL store writeDataOut into register[registerIn].
REQ-004 A write to register 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-005 readData1 and readData2 SHALL be combinational (zero-latency) reads of register[readReg1] and register[readReg2].
REQ-006 Both read ports SHALL operate independently; equal addresses SHALL return identical data.
REQ-007 writeCount SHALL increment by 1 on each committed write (REQ-003 condition true) and SHALL wrap from 0xFFFF to 0x0000.
REQ-008 Discarded writes (WriteRegIn=0, or registerIn=0) SHALL NOT change writeCount.
REQ-009 A write SHALL be visible on the read ports no later than the cycle after its clock edge.

Reset
REQ-010 While rst=1, all 32 registers SHALL be 0 and writeCount SHALL be 0, asynchronously and independent of clk.
REQ-011 A write whose clock edge coincides with asserted rst SHALL be lost.
REQ-012 After reset, readData1 and readData2 SHALL read 0 for every address until a write occurs.
REQ-013 writeDataOut SHALL remain a pure function of its inputs and SHALL NOT be affected by reset.

Configuration
REQ-014 With macro WB_REG_FILE_BYPASS_EN defined, a read whose address equals registerIn SHALL return writeDataOut in the same cycle when WriteRegIn=1 and registerIn!=0 (write-before-read bypass).
REQ-015 Without WB_REG_FILE_BYPASS_EN, reads SHALL return the stored value only; the new value SHALL appear after the clock edge.
REQ-016 Bypass SHALL never apply to address 0.

Structure
REQ-017 A shared package SHALL hold DATA_WIDTH=32, REG_ADDR_WIDTH=5, NUM_REGS=32 and WRITE_COUNT_WIDTH=16; the MEM/WB and ID stage blocks SHALL use the same constants.
REQ-018 The writeback select mux SHALL be a sub-module named wb_select; the register array, counter and bypass logic SHALL remain in wb_reg_file.

Verification
REQ-019 Reset with rst=1 mid-run after writes to r5 and r9 -> readData1 and readData2 read 0 for r5 and r9 immediately, and writeCount=0.
REQ-020 Write ALU result 0x12345678 to r3 with MemToRegIn=0 -> after the edge, readReg1=3 gives 0x12345678 and writeCount=1.
REQ-021 Write with MemToRegIn=1, dataMemoryDataIn=0xDEADBEEF, registerIn=0 -> r0 reads 0 and writeCount is unchanged.
REQ-022 Write 0xA5A5A5A5 to r7 while readReg2=7 in the same cycle -> readData2=0xA5A5A5A5 before the edge with WB_REG_FILE_BYPASS_EN, and the old value before the edge without it.
REQ-023 Perform 65536 committed writes -> writeCount wraps to 0x0000.
REQ-024 Set WriteRegIn=0 with registerIn=4 and ALUResultIn=0x1 -> r4 is unchanged and writeCount is unchanged.

Source files
------------

// File: rtl/wb_reg_file_pkg.sv
// Shared sizing constants for the writeback register file and
// the MEM/WB and ID stages that feed it.
package wb_reg_file_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int REG_ADDR_WIDTH    = 5;
  localparam int NUM_REGS          = 32;
  localparam int WRITE_COUNT_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0]        data_t;
  typedef logic [REG_ADDR_WIDTH-1:0]    reg_addr_t;
  typedef logic [WRITE_COUNT_WIDTH-1:0] write_count_t;

endpackage

// File: rtl/wb_reg_file_wb_select.sv
// wb_select: writeback value mux (memory load data vs ALU result).
// Ports: mem_to_reg, mem_data, alu_result in; write_data out.
module wb_select
  import wb_reg_file_pkg::*;
(
  input  logic  mem_to_reg,
  input  data_t mem_data,
  input  data_t alu_result,
  output data_t write_data
);

  assign write_data = mem_to_reg ? mem_data : alu_result;

endmodule

// File: rtl/wb_reg_file.sv
// wb_reg_file: 32x32 register file with writeback select, two
// combinational read ports and a committed-write counter.
// Ports: clk, rst (async, active high); MEM/WB writeback inputs;
// ID read addresses; readData1/2, writeDataOut, writeCount out.
// Optional macro WB_REG_FILE_BYPASS_EN: same-cycle write-to-read
// bypass for nonzero destination registers.
module wb_reg_file
  import wb_reg_file_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         WriteRegIn,
  input  logic         MemToRegIn,
  input  data_t        dataMemoryDataIn,
  input  data_t        ALUResultIn,
  input  reg_addr_t    registerIn,
  input  reg_addr_t    readReg1,
  input  reg_addr_t    readReg2,
  output data_t        readData1,
  output data_t        readData2,
  output data_t        writeDataOut,
  output write_count_t writeCount
);

  data_t regs [NUM_REGS];
  logic  commit;

  wb_select u_wb_select (
    .mem_to_reg (MemToRegIn),
    .mem_data   (dataMemoryDataIn),
    .alu_result (ALUResultIn),
    .write_data (writeDataOut)
  );

  // r0 is never a commit target, so it stays at its reset value.
  assign commit = WriteRegIn && (registerIn != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      writeCount <= '0;
    end else if (commit) begin
      regs[registerIn] <= writeDataOut;
      writeCount       <= writeCount + 1'b1;
    end
  end

  always_comb begin
    readData1 = regs[readReg1];
    readData2 = regs[readReg2];
`ifdef WB_REG_FILE_BYPASS_EN
    // commit already excludes r0, so r0 is never bypassed.
    if (commit && (readReg1 == registerIn))
      readData1 = writeDataOut;
    if (commit && (readReg2 == registerIn))
      readData2 = writeDataOut;
`endif
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed self-checking bench for wb_reg_file.
// Inputs change only between clock edges; outputs sampled #1 later.
module tb_wb_reg_file;

  logic        clk;
  logic        rst;
  logic        WriteRegIn;
  logic        MemToRegIn;
  logic [31:0] dataMemoryDataIn;
  logic [31:0] ALUResultIn;
  logic [4:0]  registerIn;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] writeDataOut;
  logic [15:0] writeCount;

  int n_run;
  int n_fail;
  logic [15:0] exp_cnt;
  logic [31:0] exp_r7;

  wb_reg_file dut (
    .clk              (clk),
    .rst              (rst),
    .WriteRegIn       (WriteRegIn),
    .MemToRegIn       (MemToRegIn),
    .dataMemoryDataIn (dataMemoryDataIn),
    .ALUResultIn      (ALUResultIn),
    .registerIn       (registerIn),
    .readReg1         (readReg1),
    .readReg2         (readReg2),
    .readData1        (readData1),
    .readData2        (readData2),
    .writeDataOut     (writeDataOut),
    .writeCount       (writeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One write cycle; returns #1 after the edge with the
  // enable dropped again.
  task automatic do_write(input logic [4:0]  a,
                          input logic [31:0] d,
                          input logic        mem,
                          input logic        en);
    WriteRegIn = en;
    MemToRegIn = mem;
    registerIn = a;
    if (mem) dataMemoryDataIn = d;
    else     ALUResultIn      = d;
    @(posedge clk);
    #1;
    WriteRegIn = 1'b0;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    WriteRegIn = 1'b0;
    MemToRegIn = 1'b0;
    dataMemoryDataIn = 32'h0;
    ALUResultIn = 32'h0;
    registerIn = 5'd0;
    readReg1 = 5'd5;
    readReg2 = 5'd31;
    #2;
    check("rst_rd1_r5", readData1, 32'h0);
    check("rst_rd2_r31", readData2, 32'h0);
    check("rst_cnt", {16'h0, writeCount}, 32'h0);

    // Mux is a pure function of its inputs, even in reset.
    dataMemoryDataIn = 32'hCAFEF00D;
    ALUResultIn = 32'h0BADC0DE;
    MemToRegIn = 1'b1;
    #1;
    check("mux_mem_rst", writeDataOut, 32'hCAFEF00D);
    MemToRegIn = 1'b0;
    #1;
    check("mux_alu_rst", writeDataOut, 32'h0BADC0DE);

    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 16'h0;

    // ALU write to r3
    do_write(5'd3, 32'h12345678, 1'b0, 1'b1);
    exp_cnt++;
    readReg1 = 5'd3;
    readReg2 = 5'd3;
    #1;
    check("r3_rd1", readData1, 32'h12345678);
    check("r3_rd2_same", readData2, 32'h12345678);
    check("cnt_after_r3", {16'h0, writeCount},
          {16'h0, exp_cnt});

    // memory write aimed at r0 is dropped
    MemToRegIn = 1'b1;
    dataMemoryDataIn = 32'hDEADBEEF;
    #1;
    check("mux_mem", writeDataOut, 32'hDEADBEEF);
    do_write(5'd0, 32'hDEADBEEF, 1'b1, 1'b1);
    readReg1 = 5'd0;
    #1;
    check("r0_zero", readData1, 32'h0);
    check("cnt_r0", {16'h0, writeCount}, {16'h0, exp_cnt});

    // memory write to r10
    do_write(5'd10, 32'h00C0FFEE, 1'b1, 1'b1);
    exp_cnt++;
    readReg1 = 5'd10;
    readReg2 = 5'd3;
    #1;
    check("r10_mem", readData1, 32'h00C0FFEE);
    check("r3_keep", readData2, 32'h12345678);

    // disabled write to r4
    do_write(5'd4, 32'h1, 1'b0, 1'b0);
    readReg1 = 5'd4;
    #1;
    check("r4_nowr", readData1, 32'h0);
    check("cnt_nowr", {16'h0, writeCount}, {16'h0, exp_cnt});

    // same-cycle read of r7 while it is being written
    do_write(5'd7, 32'h11111111, 1'b0, 1'b1);
    exp_cnt++;
    WriteRegIn = 1'b1;
    MemToRegIn = 1'b0;
    ALUResultIn = 32'hA5A5A5A5;
    registerIn = 5'd7;
    readReg1 = 5'd3;
    readReg2 = 5'd7;
    #1;
`ifdef WB_REG_FILE_BYPASS_EN
    exp_r7 = 32'hA5A5A5A5;
`else
    exp_r7 = 32'h11111111;
`endif
    check("r7_pre_edge", readData2, exp_r7);
    check("r3_no_byp", readData1, 32'h12345678);
    @(posedge clk);
    #1;
    WriteRegIn = 1'b0;
    exp_cnt++;
    check("r7_post_edge", readData2, 32'hA5A5A5A5);

    // never bypass r0
    WriteRegIn = 1'b1;
    registerIn = 5'd0;
    readReg1 = 5'd0;
    #1;
    check("r0_no_byp", readData1, 32'h0);
    WriteRegIn = 1'b0;
    check("cnt_mid", {16'h0, writeCount}, {16'h0, exp_cnt});

    // mid-run async reset after r5/r9 writes
    do_write(5'd5, 32'h55555555, 1'b0, 1'b1);
    do_write(5'd9, 32'h99999999, 1'b0, 1'b1);
    readReg1 = 5'd5;
    readReg2 = 5'd9;
    #1;
    check("r5_set", readData1, 32'h55555555);
    check("r9_set", readData2, 32'h99999999);
    rst = 1'b1;
    #1;
    check("arst_r5", readData1, 32'h0);
    check("arst_r9", readData2, 32'h0);
    check("arst_cnt", {16'h0, writeCount}, 32'h0);
    check("arst_mux", writeDataOut, 32'h99999999);

    // write on an edge while reset is held is lost
    do_write(5'd6, 32'h66666666, 1'b0, 1'b1);
    rst = 1'b0;
    readReg1 = 5'd6;
    #1;
    check("rst_wr_lost", readData1, 32'h0);
    check("rst_wr_cnt", {16'h0, writeCount}, 32'h0);

    // 65536 committed writes wrap the counter
    for (int i = 0; i < 65535; i++)
      do_write(5'd1 + 5'(i % 31), 32'(i), 1'b0, 1'b1);
    check("cnt_ffff", {16'h0, writeCount}, 32'h0000FFFF);
    do_write(5'd2, 32'h2, 1'b0, 1'b1);
    check("cnt_wrap", {16'h0, writeCount}, 32'h0);
    do_write(5'd2, 32'h3, 1'b0, 1'b1);
    check("cnt_after_wrap", {16'h0, writeCount}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
